antilog64: RTL

- Log-to-linear converter. This is the inverse of the leading-one detector and log encoder in the ReMap logarithmic datapath.
- Input: a log-domain value {characteristic k, fraction f}, typically the sum of two operand logs.
- Output: the integer Mitchell antilog, floor(2^k * (1 + f)), as a 64-bit product.
- 2-stage pipeline with valid/ready handshake. Sits between the log adder and the result writeback.

---
 rtl/antilog64_pkg.sv | 16 +
 rtl/antilog64_if.sv | 23 ++
 rtl/antilog_shift_stage.sv | 42 ++++
 rtl/antilog64.sv | 49 ++++
 4 files changed

// File: rtl/antilog64_pkg.sv
// Shared widths and sideband layout for the log-to-linear (Mitchell antilog) converter.
package antilog64_pkg;
  localparam int FRAC_W   = 31;
  localparam int CHAR_W   = 6;
  localparam int OUT_W    = 64;
  localparam int TAG_W    = 4;
  localparam int M_W      = FRAC_W + 1;   // 1.FRAC_W mantissa
  localparam int COARSE_W = M_W + 56;     // after k[5:3]*8, max 56
  localparam int FINE_W   = COARSE_W + 7; // after k[2:0], equals OUT_W + FRAC_W

  typedef struct packed {
    logic [2:0]       k_fine;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } s1_side_t;
endpackage

// File: rtl/antilog64_if.sv
// Input log-value / output linear-result handshake bundle.
interface antilog64_if;
  import antilog64_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_k;
  logic [FRAC_W-1:0] in_frac;
  logic              in_zero;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_num;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_k, in_frac, in_zero, in_tag, out_ready,
    input  in_ready, out_valid, out_num, out_tag
  );
  modport slave (
    input  in_valid, in_k, in_frac, in_zero, in_tag, out_ready,
    output in_ready, out_valid, out_num, out_tag
  );
endinterface

// File: rtl/antilog_shift_stage.sv
// Registered left-shifter stage: shift by sel*STEP, carry sideband, load on advance.
module antilog_shift_stage #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 88,
  parameter int SEL_W  = 3,
  parameter int STEP   = 8,
  parameter int SIDE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  din,
  input  logic [SEL_W-1:0]  sel,
  input  logic [SIDE_W-1:0] side_in,
  output logic              valid,
  output logic [DOUT_W-1:0] dout,
  output logic [SIDE_W-1:0] side_out
);
  logic [DOUT_W-1:0] ext;
  logic [DOUT_W-1:0] shifted;
  logic [31:0]       amt;

  assign ext     = DOUT_W'(din);
  assign amt     = 32'(sel) * 32'(STEP);
  assign shifted = ext << amt;

  // data is reset too so the final stage presents zeros out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      dout     <= '0;
      side_out <= '0;
    end else if (adv) begin
      valid <= in_valid;
      if (in_valid) begin
        dout     <= shifted;
        side_out <= side_in;
      end
    end
  end
endmodule

// File: rtl/antilog64.sv
// Mitchell antilog: floor(2^k * (1+f)) as a 2-stage coarse/fine shift pipeline.
module antilog64 import antilog64_pkg::*; (
  input logic         clk,
  input logic         rst_n,
  antilog64_if.slave  bus
);
  logic                s1_valid, s2_valid;
  logic                s1_adv, s2_adv;
  logic [2:0]          vld_pipe;
  logic [COARSE_W-1:0] s1_data;
  logic [COARSE_W-1:0] s2_din;
  logic [FINE_W-1:0]   s2_data;
  s1_side_t            s1_side_in, s1_side;
  logic [TAG_W-1:0]    s2_tag;
  logic                unused_lo;

  assign vld_pipe = {s2_valid, s1_valid, bus.in_valid};

  // no skid buffer: in_ready ripples straight back from out_ready
  assign s2_adv       = !vld_pipe[2] | bus.out_ready;
  assign s1_adv       = !vld_pipe[1] | s2_adv;
  assign bus.in_ready = s1_adv;

  assign s1_side_in = '{k_fine: bus.in_k[2:0], zero: bus.in_zero, tag: bus.in_tag};

  antilog_shift_stage #(
    .DIN_W(M_W), .DOUT_W(COARSE_W), .SEL_W(3), .STEP(8), .SIDE_W($bits(s1_side_t))
  ) u_coarse (
    .clk(clk), .rst_n(rst_n), .adv(s1_adv), .in_valid(vld_pipe[0]),
    .din({1'b1, bus.in_frac}), .sel(bus.in_k[5:3]), .side_in(s1_side_in),
    .valid(s1_valid), .dout(s1_data), .side_out(s1_side)
  );

  // zero operands are flushed before the fine shift so the result register holds 0
  assign s2_din = s1_side.zero ? '0 : s1_data;

  antilog_shift_stage #(
    .DIN_W(COARSE_W), .DOUT_W(FINE_W), .SEL_W(3), .STEP(1), .SIDE_W(TAG_W)
  ) u_fine (
    .clk(clk), .rst_n(rst_n), .adv(s2_adv), .in_valid(vld_pipe[1]),
    .din(s2_din), .sel(s1_side.k_fine), .side_in(s1_side.tag),
    .valid(s2_valid), .dout(s2_data), .side_out(s2_tag)
  );

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_num   = s2_data[FRAC_W +: OUT_W];
  assign bus.out_tag   = s2_tag;
  assign unused_lo     = ^s2_data[FRAC_W-1:0];
endmodule
